dlsc_pipedelay_sink: RTL and testbench
======================================

DLSC_PIPEDELAY_SINK -- requirements
Module: dlsc_pipedelay_sink

Interface
REQ-001 The block SHALL have parameter DELAY, default 1: fixed latency in cycles from an issue strobe to the matching result on pipe_data (>= 1).
REQ-002 The block SHALL have parameter DATA, default 1: width of result data.
REQ-003 The block SHALL have parameter DEPTH, default 4: total credits, in-flight plus stored (>= DELAY+2 for full throughput, >= 2 always).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream requests an issue this cycle.
REQ-007 in_ready  output  1  registered; a credit is available.
REQ-008 issue  output  1  in_valid && in_ready; the external fixed-latency pipeline starts an operation.
REQ-009 pipe_data  input  DATA  pipeline result, valid exactly DELAY cycles after the corresponding issue.
REQ-010 out_valid  output  1  out_data holds the oldest stored result.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  DATA  oldest stored result.
REQ-013 count  output  clog2(DEPTH+1)  outstanding items, issued but not yet popped.

Function
REQ-014 An issue SHALL occur in a cycle with in_valid=1 and in_ready=1; a pop SHALL occur in a cycle with out_valid=1 and out_ready=1.
REQ-015 A 1-bit, DELAY-stage valid delay line SHALL track issues; when its output is set, pipe_data SHALL be written to the storage at that clock edge.
REQ-016 The minimum latency from an issue cycle to out_valid SHALL be DELAY+1 cycles; there is no bypass path.
REQ-017 The storage SHALL be an in-order circular buffer of DEPTH entries; read and write pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, not only powers of two.
REQ-018 count SHALL update as follows: +1 on an issue, -1 on a pop, and unchanged when both occur in the same cycle.
REQ-019 in_ready SHALL be registered, with next value = (count_next < DEPTH); upstream is never over-committed.
REQ-020 When count=DEPTH and a pop occurs, in_ready SHALL rise on the following cycle.
REQ-021 out_valid SHALL be 1 whenever the storage is non-empty; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 A write and a pop in the same cycle SHALL both complete, including when storage holds exactly 1 entry or DEPTH-1 entries.
REQ-023 Storage overflow SHALL be impossible by construction; a simulation-only check SHALL flag a write into full storage and a pop with count=0.
REQ-024 With DEPTH >= DELAY+2 and out_ready held at 1, the block SHALL sustain one issue per cycle indefinitely.

Reset
REQ-025 While rst_n=0, the block SHALL clear the valid delay line, pointers and count; in_ready=0, out_valid=0, issue=0, count=0.
REQ-026 out_data SHALL have no reset requirement; storage RAM SHALL be unreset.
REQ-027 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight and stored items; pipe_data arriving afterwards SHALL be ignored.

Structure
REQ-029 No shared package is needed; width derivation SHALL use the codebase's common clog2 include.
REQ-030 The valid delay line SHALL be the sub-module dlsc_pipedelay_arst_slice (DATA=1, async active-low reset to 0, no clock enable).
REQ-031 The storage and pointer logic SHALL reside in the top module.

Verification
Bench setup: DELAY=3, DEPTH=5, DATA=8; the bench models the pipeline as pipe_data = issued value + 1, delayed 3 cycles.
REQ-032 Single issue: issue of 0x10 in cycle 0 -> out_valid in cycle 4 with out_data=0x11; count goes 1 then 0 after the pop.
REQ-033 Backpressure: out_ready=0 with in_valid=1 continuous -> exactly 5 issues, in_ready=0 from the cycle after the 5th, count=5; releasing out_ready -> 5 in-order outputs, then in_ready returns to 1.
REQ-034 Throughput: out_ready=1 with in_valid=1 for 20 cycles -> 20 back-to-back issues, in_ready never low, outputs on 20 consecutive cycles in order.
REQ-035 Full plus pop: at count=5, a pop with no issue -> count=4 and in_ready=1 on the next cycle; a simultaneous issue and pop at count=4 -> count stays 4.
REQ-036 Reset mid-operation: drive rst_n=0 with 2 items in flight and 2 stored -> out_valid=0 immediately (asynchronously); after release, no outputs appear despite pipe_data toggling, count=0, and in_ready=1 one edge later.

Source files
------------

// File: rtl/dlsc_pipedelay_arst_slice.sv
// ---------------------------------------------------------------------------
// dlsc_pipedelay_arst_slice
//   Plain DELAY-stage shift register with asynchronous active-low reset to 0
//   and no clock enable. Used as the valid-tracking delay line that mirrors
//   the external fixed-latency pipeline.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears every stage to 0
//   in_data   value entering the first stage
//   out_data  value leaving the last stage (DELAY cycles after entry)
// ---------------------------------------------------------------------------
module dlsc_pipedelay_arst_slice #(
    parameter int DATA  = 1,
    parameter int DELAY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DATA-1:0] in_data,
    output logic [DATA-1:0] out_data
);

    logic [DATA-1:0] stage [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_data;
            for (int i = 1; i < DELAY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_data = stage[DELAY-1];

endmodule

// File: rtl/dlsc_pipedelay_sink.sv
// ---------------------------------------------------------------------------
// dlsc_pipedelay_sink
//   Credit-based sink for an external fixed-latency pipeline. Upstream issues
//   operations only while a credit is free; each result arrives on pipe_data
//   exactly DELAY cycles later, is captured into an in-order circular buffer
//   and is presented downstream through a valid/ready output.
//
// Handshake rule (both sides): a transfer happens in a cycle where valid and
//   ready are both 1. valid never depends on ready. out_data is held stable
//   while out_valid=1 and out_ready=0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream wants to issue an operation
//   in_ready   registered; a credit is available
//   issue      in_valid && in_ready; external pipeline starts an operation
//   pipe_data  pipeline result, valid DELAY cycles after its issue
//   out_valid  storage non-empty; out_data holds the oldest result
//   out_ready  downstream accepts out_data
//   out_data   oldest stored result
//   count      items issued but not yet popped (in flight + stored)
// ---------------------------------------------------------------------------
module dlsc_pipedelay_sink #(
    parameter int DELAY = 1,
    parameter int DATA  = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       issue,
    input  logic [DATA-1:0]            pipe_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

    logic [DATA-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fill;
    logic [CW-1:0]   fill_next;
    logic [CW-1:0]   count_next;
    logic            pipe_valid;
    logic            pop;

    // Explicit wrap so any DEPTH works, not only powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign issue     = in_valid && in_ready;
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Mirrors the external pipeline: its output marks the cycle in which
    // pipe_data carries a result that must be captured.
    dlsc_pipedelay_arst_slice #(
        .DATA  (1),
        .DELAY (DELAY)
    ) u_valid_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (issue),
        .out_data (pipe_valid)
    );

    always_comb begin
        count_next = count;
        case ({issue, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        fill_next = fill;
        case ({pipe_valid, pop})
            2'b10:   fill_next = fill + CW'(1);
            2'b01:   fill_next = fill - CW'(1);
            default: fill_next = fill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (pipe_valid) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)        rd_ptr <= ptr_inc(rd_ptr);
            fill     <= fill_next;
            count    <= count_next;
            // Credits cover in-flight items too, so storage cannot overflow.
            in_ready <= (count_next < CNT_MAX);
        end
    end

    // Storage is deliberately unreset.
    always_ff @(posedge clk) begin
        if (pipe_valid) mem[wr_ptr] <= pipe_data;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(pipe_valid && (fill == CNT_MAX)))
                else $error("dlsc_pipedelay_sink: write into full storage");
            assert (!(pop && (count == '0)))
                else $error("dlsc_pipedelay_sink: pop with count=0");
        end
    end
`endif

endmodule

// File: tb/tb_dlsc_pipedelay_sink.sv
// ---------------------------------------------------------------------------
// tb_dlsc_pipedelay_sink
//   Bench for dlsc_pipedelay_sink with DELAY=3, DEPTH=5, DATA=8. The external
//   pipeline is modelled as pipe_data = issued value + 1, three cycles later;
//   idle pipeline cycles drive random garbage. The reference model is a
//   result queue plus a map of pending arrivals keyed by cycle number.
// ---------------------------------------------------------------------------
module tb_dlsc_pipedelay_sink;

    localparam int DELAY = 3;
    localparam int DEPTH = 5;
    localparam int DATA  = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b0;
    logic [DATA-1:0] pipe_data = '0;
    logic            in_ready;
    logic            issue;
    logic            out_valid;
    logic [DATA-1:0] out_data;
    logic [CW-1:0]   count;

    dlsc_pipedelay_sink #(
        .DELAY (DELAY),
        .DATA  (DATA),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .issue     (issue),
        .pipe_data (pipe_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // ---------------- clock ----------------
    initial begin
        forever #5 clk = ~clk;
    end

    // ---------------- environment + reference model state ----------------
    int              cyc = 0;
    logic [DATA-1:0] sched     [int];  // pipeline drive: cycle -> pipe_data
    logic [DATA-1:0] model_arr [int];  // model: cycle -> result captured at its end
    logic [DATA-1:0] store_q   [$];    // model: stored results, oldest first
    int              mcount = 0;
    bit              mready = 1'b0;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int n_issue = 0;
    int n_out = 0;
    int n_notready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        store_q.delete();
        model_arr.delete();
        mcount = 0;
        mready = 1'b0;
    endtask

    // One clock cycle. Entered at posedge+1; inputs applied, outputs checked
    // at posedge+4, model advanced at the edge.
    task automatic cycle(input bit iv, input bit orr, input logic [DATA-1:0] val);
        bit mpop;
        bit missue;
        in_valid  = iv;
        out_ready = orr;
        if (sched.exists(cyc)) begin
            pipe_data = sched[cyc];
            sched.delete(cyc);
        end else begin
            pipe_data = DATA'($urandom);
        end
        #3;
        chk("in_ready", 32'(in_ready), 32'(mready));
        chk("issue", 32'(issue), 32'(iv && mready));
        chk("count", 32'(count), 32'(mcount));
        chk("out_valid", 32'(out_valid), 32'(store_q.size() > 0));
        if (store_q.size() > 0) chk("out_data", 32'(out_data), 32'(store_q[0]));
        // The pipeline reacts to the real issue strobe.
        if (issue) begin
            n_issue++;
            sched[cyc + DELAY] = val + DATA'(1);
        end
        if (out_valid && out_ready) n_out++;
        if (!in_ready) n_notready++;
        @(posedge clk);
        if (rst_n) begin
            mpop   = (store_q.size() > 0) && orr;
            missue = iv && mready;
            if (mpop) void'(store_q.pop_front());
            if (model_arr.exists(cyc)) begin
                store_q.push_back(model_arr[cyc]);
                model_arr.delete(cyc);
            end
            if (missue) model_arr[cyc + DELAY] = val + DATA'(1);
            mcount = mcount + int'(missue) - int'(mpop);
            mready = (mcount < DEPTH);
        end
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit orr);
        for (int i = 0; i < n; i++) cycle(1'b0, orr, DATA'($urandom));
    endtask

    // ---------------- directed + random sequence ----------------
    int base_issue;
    int base_out;
    int base_nr;

    initial begin
        // Reset: outputs quiet even with in_valid asserted.
        model_reset();
        cycle(1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h00);
        rst_n = 1'b1;
        // First edge after release raises in_ready.
        idle(1, 1'b0);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Single issue: 0x10 -> 0x11 visible four cycles later.
        cycle(1'b1, 1'b0, 8'h10);
        chk("single_count1", 32'(count), 32'd1);
        idle(3, 1'b1);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h11);
        idle(1, 1'b1);
        chk("single_count0", 32'(count), 32'd0);
        chk("single_empty", 32'(out_valid), 32'd0);

        // Backpressure: out_ready low, continuous in_valid.
        base_issue = n_issue;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DATA'($urandom));
        chk("bp_issues", 32'(n_issue - base_issue), 32'd5);
        chk("bp_count", 32'(count), 32'd5);
        chk("bp_ready", 32'(in_ready), 32'd0);

        // Full plus pop, then simultaneous issue and pop at count=4.
        cycle(1'b0, 1'b1, DATA'($urandom));
        chk("fullpop_count", 32'(count), 32'd4);
        chk("fullpop_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 1'b1, DATA'($urandom));
        chk("issue_pop_count", 32'(count), 32'd4);

        // Drain, credits return.
        idle(12, 1'b1);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd1);

        // Throughput: 20 back-to-back issues.
        base_issue = n_issue;
        base_out   = n_out;
        base_nr    = n_notready;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, DATA'($urandom));
        idle(DELAY + 1, 1'b1);
        chk("tput_issues", 32'(n_issue - base_issue), 32'd20);
        chk("tput_notready", 32'(n_notready - base_nr), 32'd0);
        chk("tput_outputs", 32'(n_out - base_out), 32'd20);

        // Reset mid-operation: 2 stored, 2 in flight.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DATA'($urandom));
        idle(1, 1'b0);
        chk("pre_rst_stored", 32'(out_valid), 32'd1);
        chk("pre_rst_count", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_ready", 32'(in_ready), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        base_out = n_out;
        idle(6, 1'b1);
        chk("post_rst_outputs", 32'(n_out - base_out), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), DATA'($urandom));
        end
        idle(12, 1'b1);
        chk("final_count", 32'(count), 32'd0);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
